serializador: RTL and testbench

Parallel-to-serial transmitter: accepts one byte from a producer over a four-phase valid/ack handshake and shifts it out MSB-first, one bit per clock, on `data_out` qualified by `write_out`. Its serial side drives the deserializer's `data_in`/`write_in` inputs, and its `status_in` takes the deserializer's `status_out`, so a pending word stalls transmission. The block sits on the producer side of the 100 kHz serial link.

---
 rtl/serializador.sv | 134 +++++++++++++
 tb/tb_serializador.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serializador.sv
// MSB-first parallel-to-serial transmitter with a four-phase valid/ack capture handshake.
// Define SERIALIZADOR_PARITY_EN to append an even-parity bit after each word.
module serializador #(
   parameter int WIDTH = 8
) (
   input  logic             clk_100KHz,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   input  logic             status_in,
   output logic             data_out,
   output logic             write_out,
   output logic             ack_out,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIALIZADOR_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, WAIT_REL} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_REL} state_t;
`endif

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             data_out_n, write_out_n, ack_out_n, busy_n;
`ifdef SERIALIZADOR_PARITY_EN
   logic             par, par_n;
`endif

   always_comb begin
      // NOTE: every next value is given a default first so no path leaves it unassigned (no latches).
      state_n     = state;
      shreg_n     = shreg;
      cnt_n       = cnt;
      data_out_n  = data_out;
      write_out_n = write_out;
      ack_out_n   = ack_out;
`ifdef SERIALIZADOR_PARITY_EN
      par_n       = par;
`endif

      // Release of the handshake is honoured in every state.
      if (ack_out && !data_valid)
         ack_out_n = 1'b0;

      unique case (state)
         IDLE: begin
            if (data_valid && !ack_out) begin
               shreg_n   = data_in;
               ack_out_n = 1'b1;
               cnt_n     = '0;
`ifdef SERIALIZADOR_PARITY_EN
               par_n     = 1'b0;
`endif
               state_n   = SHIFT;
            end
         end

         SHIFT: begin
            if (status_in) begin
               write_out_n = 1'b0;
            end else if (cnt == CW'(WIDTH)) begin
`ifdef SERIALIZADOR_PARITY_EN
               // Parity goes out on the edge right after the last data bit.
               data_out_n  = par;
               write_out_n = 1'b1;
               state_n     = PARITY;
`else
               write_out_n = 1'b0;
               state_n     = WAIT_REL;
`endif
            end else begin
               data_out_n  = shreg[WIDTH-1];
               write_out_n = 1'b1;
               shreg_n     = {shreg[WIDTH-2:0], 1'b0};
               cnt_n       = cnt + CW'(1);
`ifdef SERIALIZADOR_PARITY_EN
               par_n       = par ^ shreg[WIDTH-1];
`endif
            end
         end

`ifdef SERIALIZADOR_PARITY_EN
         PARITY: begin
            write_out_n = 1'b0;
            if (!status_in)
               state_n = WAIT_REL;
         end
`endif

         WAIT_REL: begin
            write_out_n = 1'b0;
            // ack already released during SHIFT means the producer is done with this word.
            if (!data_valid || !ack_out)
               state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_100KHz or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         data_out  <= 1'b0;
         write_out <= 1'b0;
         ack_out   <= 1'b0;
         busy      <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         cnt       <= cnt_n;
         data_out  <= data_out_n;
         write_out <= write_out_n;
         ack_out   <= ack_out_n;
         busy      <= busy_n;
`ifdef SERIALIZADOR_PARITY_EN
         par       <= par_n;
`endif
      end
   end

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: a bit scoreboard is filled when a word is offered
// and drained by a negedge monitor of the serial strobes.
`timescale 1us/1ns
module tb_serializador;

`ifdef SERIALIZADOR_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       clk_100KHz = 1'b0;
   logic       reset      = 1'b0;
   logic [7:0] data_in    = '0;
   logic       data_valid = 1'b0;
   logic       status_in  = 1'b0;
   logic       data_out, write_out, ack_out, busy;

   int   checks_total  = 0;
   int   checks_passed = 0;
   bit   exp_q[$];

   serializador #(.WIDTH(8)) dut (
      .clk_100KHz(clk_100KHz),
      .reset     (reset),
      .data_in   (data_in),
      .data_valid(data_valid),
      .status_in (status_in),
      .data_out  (data_out),
      .write_out (write_out),
      .ack_out   (ack_out),
      .busy      (busy)
   );

   always #5 clk_100KHz = ~clk_100KHz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_100KHz);
      #1;
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SERIALIZADOR_PARITY_EN
      exp_q.push_back(^w);
`endif
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 20 && busy !== 1'b0; i++) tick();
      check(tag, busy, 1'b0);
   endtask

   // Offers one word, optionally stalls the serial side, and checks strobe count and span.
   task automatic run_word(input logic [7:0] w, input int stall_at, input int stall_len,
                           input bit hold, input string tag);
      int n, first, last;
      n = 0; first = -1; last = -1;
      data_in    = w;
      data_valid = 1'b1;
      push_word(w);
      tick();
      check({tag, " ack@E0"},  ack_out, 1'b1);
      check({tag, " busy@E0"}, busy, 1'b1);
      if (!hold) data_valid = 1'b0;
      for (int cyc = 1; cyc <= NB + stall_len + 3; cyc++) begin
         status_in = (cyc > stall_at) && (cyc <= stall_at + stall_len);
         tick();
         if (cyc == 1 && !hold) check({tag, " ack released"}, ack_out, 1'b0);
         if (write_out) begin
            n++;
            if (first < 0) first = cyc;
            last = cyc;
         end
      end
      status_in = 1'b0;
      check({tag, " strobes"},    n, NB);
      check({tag, " first"},      first, 1);
      check({tag, " last"},       last, NB + stall_len);
   endtask

   always @(negedge clk_100KHz) begin
      if (reset && write_out) begin
         if (exp_q.size() == 0) check("unexpected strobe", 1, 0);
         else check("serial bit", data_out, exp_q.pop_front());
      end
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk_100KHz);
      #1;
      check("in reset", {data_out, write_out, ack_out, busy}, 4'b0);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle after reset", {data_out, write_out, ack_out, busy}, 4'b0);
      end

      // Plain word with one-cycle handshake
      run_word(8'hA5, 0, 0, 1'b0, "A5");
      wait_idle("A5 idle");

      // Downstream stall of three cycles after the third bit
      tick();
      run_word(8'hA5, 3, 3, 1'b0, "A5 stall");
      wait_idle("A5 stall idle");

      // Producer holds data_valid through the whole word
      tick();
      run_word(8'hA5, 0, 0, 1'b1, "A5 hold");
      check("hold ack", ack_out, 1'b1);
      check("hold busy", busy, 1'b1);
      data_valid = 1'b0;
      tick();
      check("release ack", ack_out, 1'b0);
      check("release idle", busy, 1'b0);
      run_word(8'h3C, 0, 0, 1'b0, "3C");
      wait_idle("3C idle");

      // Asynchronous reset in the middle of a word
      tick();
      data_in    = 8'hFF;
      data_valid = 1'b1;
      push_word(8'hFF);
      tick();
      data_valid = 1'b0;
      repeat (4) tick();
      check("FF mid-word strobe", write_out, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("async reset", {data_out, write_out, ack_out, busy}, 4'b0);
      exp_q.delete();
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("after reset idle", {data_out, write_out, ack_out, busy}, 4'b0);
      run_word(8'h81, 0, 0, 1'b0, "81");
      wait_idle("81 idle");

      // Word whose parity bit is set
      tick();
      run_word(8'h07, 0, 0, 1'b0, "07");
      wait_idle("07 idle");

      repeat (3) tick();
      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
